// File: rtl/afifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// afifo_wr_arbiter
//   Write-side scheduler for the async FIFO. Shares the single wclk-domain
//   write port among NUM_REQ requesters using round-robin arbitration with
//   bounded bursts. A one-entry holding register decouples grants from wfull,
//   so an accepted word is never dropped. Counts cycles stalled on wfull.
//
// Ports
//   wclk           in   write clock
//   wrst           in   synchronous active-high reset
//   req            in   per-requester word-valid, held until granted
//   req_data       in   requester i word at [i*DATA_WIDTH +: DATA_WIDTH]
//   gnt            out  one-hot/zero grant (combinational)
//   winc           out  FIFO write enable
//   wdata          out  FIFO write data (holding register)
//   wfull          in   FIFO full flag
//   owner          out  current/last granted requester
//   busy           out  holding register valid or burst in progress
//   full_stall_cnt out  saturating count of cycles with a word stalled on wfull
// -----------------------------------------------------------------------------
module afifo_wr_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 32,
   parameter int BURST_LEN  = 4,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                            wclk,
   input  logic                            wrst,
   input  logic [NUM_REQ-1:0]              req,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
   output logic [NUM_REQ-1:0]              gnt,
   output logic                            winc,
   output logic [DATA_WIDTH-1:0]           wdata,
   input  logic                            wfull,
   output logic [$clog2(NUM_REQ)-1:0]      owner,
   output logic                            busy,
   output logic [CNT_WIDTH-1:0]            full_stall_cnt
);

   localparam int OW = $clog2(NUM_REQ);
   localparam int BW = $clog2(BURST_LEN + 1);

   typedef enum logic {ARB, BURST} state_t;

   state_t                r_state, w_state_nxt;
   logic                  r_hold_vld;
   logic [DATA_WIDTH-1:0] r_hold_data;
   logic [OW-1:0]         r_owner, w_owner_nxt;
   logic [OW-1:0]         r_rr_last, w_rr_nxt;
   logic [BW-1:0]         r_beats, w_beats_nxt;
   logic [CNT_WIDTH-1:0]  r_stall_cnt;

   logic                  w_accept_ok;
   logic                  w_accept;
   logic                  w_found;
   logic [OW-1:0]         w_winner;
   logic [OW-1:0]         w_sel;

   // Slot is free, or the held word drains at this same edge.
   assign w_accept_ok = ~r_hold_vld | ~wfull;

   // Round-robin search starting just after the last winner.
   always_comb begin
      w_found  = 1'b0;
      w_winner = '0;
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
         if (!w_found && req[(32'(r_rr_last) + k) % NUM_REQ]) begin
            w_found  = 1'b1;
            w_winner = OW'((32'(r_rr_last) + k) % NUM_REQ);
         end
      end
   end

   always_comb begin
      gnt         = '0;
      w_state_nxt = r_state;
      w_owner_nxt = r_owner;
      w_rr_nxt    = r_rr_last;
      w_beats_nxt = r_beats;
      w_sel       = r_owner;
      if (!wrst) begin
         case (r_state)
            ARB: begin
               if (w_accept_ok && w_found) begin
                  gnt[w_winner] = 1'b1;
                  w_sel         = w_winner;
                  w_owner_nxt   = w_winner;
                  w_rr_nxt      = w_winner;
                  w_beats_nxt   = BW'(1);
                  w_state_nxt   = (BURST_LEN > 1) ? BURST : ARB;
               end
            end
            BURST: begin
               if (!req[r_owner]) begin
                  // Owner went idle: give up the burst, costs one bubble.
                  w_state_nxt = ARB;
               end else if (w_accept_ok) begin
                  gnt[r_owner] = 1'b1;
                  w_beats_nxt  = r_beats + 1'b1;
                  if (r_beats + 1'b1 == BW'(BURST_LEN)) w_state_nxt = ARB;
               end
            end
            default: w_state_nxt = ARB;
         endcase
      end
   end

   assign w_accept = |gnt;

   always_ff @(posedge wclk) begin
      if (wrst) begin
         r_state     <= ARB;
         r_hold_vld  <= 1'b0;
         r_hold_data <= '0;
         r_owner     <= '0;
         r_rr_last   <= OW'(NUM_REQ - 1);
         r_beats     <= '0;
         r_stall_cnt <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_owner   <= w_owner_nxt;
         r_rr_last <= w_rr_nxt;
         r_beats   <= w_beats_nxt;
         if (w_accept) begin
            r_hold_vld  <= 1'b1;
            r_hold_data <= req_data[32'(w_sel)*DATA_WIDTH +: DATA_WIDTH];
         end else if (winc) begin
            r_hold_vld <= 1'b0;
         end
         if (r_hold_vld && wfull && (r_stall_cnt != '1))
            r_stall_cnt <= r_stall_cnt + 1'b1;
      end
   end

   assign winc           = r_hold_vld & ~wfull & ~wrst;
   assign wdata          = r_hold_data;
   assign owner          = r_owner;
   assign busy           = r_hold_vld | (r_state == BURST);
   assign full_stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_afifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_afifo_wr_arbiter
//   Self-checking bench for afifo_wr_arbiter. A vector table drives the
//   grant/write sequences; hand-written sequences cover wfull stalls and
//   counter saturation. Accepted words go into a scoreboard queue and are
//   popped and compared whenever winc is seen.
// -----------------------------------------------------------------------------
module tb_afifo_wr_arbiter;

   localparam int NR = 4;
   localparam int DW = 16;
   localparam int BL = 4;
   localparam int CW = 3;

   logic            wclk = 1'b0;
   logic            wrst;
   logic [NR-1:0]   req;
   logic [NR*DW-1:0] req_data;
   logic [NR-1:0]   gnt;
   logic            winc;
   logic [DW-1:0]   wdata;
   logic            wfull;
   logic [1:0]      owner;
   logic            busy;
   logic [CW-1:0]   full_stall_cnt;

   always #5 wclk = ~wclk;

   afifo_wr_arbiter #(
      .NUM_REQ   (NR),
      .DATA_WIDTH(DW),
      .BURST_LEN (BL),
      .CNT_WIDTH (CW)
   ) dut (
      .wclk          (wclk),
      .wrst          (wrst),
      .req           (req),
      .req_data      (req_data),
      .gnt           (gnt),
      .winc          (winc),
      .wdata         (wdata),
      .wfull         (wfull),
      .owner         (owner),
      .busy          (busy),
      .full_stall_cnt(full_stall_cnt)
   );

   typedef struct {
      logic       rst;
      logic [3:0] req;
      logic [3:0] gnt;
      logic       winc;
   } vec_t;

   vec_t        tv[$];
   logic [DW-1:0] sb[$];
   logic [11:0] seqn[NR];
   int          checks = 0;
   int          errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic add(input logic rst, input logic [3:0] r, input logic [3:0] g, input logic w);
      vec_t v;
      v.rst = rst; v.req = r; v.gnt = g; v.winc = w;
      tv.push_back(v);
   endtask

   // One clock: drive at negedge, sample 1ns later, the DUT acts at the next posedge.
   task automatic cyc(input logic rst, input logic [3:0] r, input logic full,
                      input logic [3:0] eg, input logic ew, input string name);
      logic [DW-1:0] w;
      @(negedge wclk);
      wrst  = rst;
      req   = r;
      wfull = full;
      for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = {4'(i), seqn[i]};
      #1;
      chk({name, " gnt"},  32'(gnt),  32'(eg));
      chk({name, " winc"}, 32'(winc), 32'(ew));
      chk({name, " gnt legal"}, 32'(((gnt & ~req) == '0) && $onehot0(gnt)), 32'd1);
      if (winc) begin
         chk({name, " write has queued word"}, 32'(sb.size() != 0), 32'd1);
         if (sb.size() != 0) begin
            w = sb.pop_front();
            chk({name, " wdata"}, 32'(wdata), 32'(w));
         end
      end
      for (int i = 0; i < NR; i++) begin
         if (gnt[i] && req[i]) begin
            sb.push_back(req_data[i*DW +: DW]);
            seqn[i]++;
         end
      end
      if (rst) sb.delete();
   endtask

   initial begin
      wrst = 1'b1; req = '0; wfull = 1'b0; req_data = '0;
      for (int i = 0; i < NR; i++) seqn[i] = 12'(i * 16);

      // Reset with all requests high, then the first grant goes to requester 0.
      cyc(1, 4'hF, 0, 4'h0, 0, "rst0");
      cyc(1, 4'hF, 0, 4'h0, 0, "rst1");
      cyc(0, 4'h0, 0, 4'h0, 0, "post-rst idle");
      chk("reset wdata", 32'(wdata), 32'd0);
      chk("reset stall cnt", 32'(full_stall_cnt), 32'd0);
      chk("reset owner", 32'(owner), 32'd0);
      chk("reset busy", 32'(busy), 32'd0);
      cyc(0, 4'hF, 0, 4'h1, 0, "first grant");

      // Single requester, six words: bursts of 4 then 2, no bubbles.
      add(1, 4'h0, 4'h0, 0);
      add(0, 4'h1, 4'h1, 0);
      for (int i = 0; i < 5; i++) add(0, 4'h1, 4'h1, 1);
      add(0, 4'h0, 4'h0, 1);
      add(0, 4'h0, 4'h0, 0);
      // All requesting: 0x4, 1x4, 2x4, 3x4, 0 with continuous writes.
      add(1, 4'hF, 4'h0, 0);
      add(0, 4'hF, 4'h1, 0);
      for (int i = 0; i < 3; i++) add(0, 4'hF, 4'h1, 1);
      for (int i = 0; i < 4; i++) add(0, 4'hF, 4'h2, 1);
      for (int i = 0; i < 4; i++) add(0, 4'hF, 4'h4, 1);
      for (int i = 0; i < 4; i++) add(0, 4'hF, 4'h8, 1);
      add(0, 4'hF, 4'h1, 1);
      // Reset mid-burst with a held word: it is never written.
      add(1, 4'hF, 4'h0, 0);
      add(0, 4'h0, 4'h0, 0);
      add(0, 4'hF, 4'h1, 0);
      add(0, 4'h0, 4'h0, 1);
      add(0, 4'h0, 4'h0, 0);
      // Owner 2 drops after two beats with req[3] waiting: one bubble.
      add(0, 4'h4, 4'h4, 0);
      add(0, 4'h4, 4'h4, 1);
      add(0, 4'h8, 4'h0, 1);
      add(0, 4'h8, 4'h8, 0);
      add(0, 4'h0, 4'h0, 1);
      add(0, 4'h0, 4'h0, 0);

      for (int i = 0; i < tv.size(); i++)
         cyc(tv[i].rst, tv[i].req, 1'b0, tv[i].gnt, tv[i].winc, $sformatf("vec%0d", i));

      // wfull stall: five cycles, held word stable, counter counts.
      cyc(1, 4'h0, 0, 4'h0, 0, "t4 rst");
      cyc(0, 4'h1, 0, 4'h1, 0, "t4 load");
      for (int k = 0; k < 5; k++) begin
         cyc(0, 4'h1, 1, 4'h0, 0, $sformatf("t4 stall%0d", k));
         chk($sformatf("t4 stall%0d wdata", k), 32'(wdata), 32'(sb[0]));
         chk($sformatf("t4 stall%0d cnt", k), 32'(full_stall_cnt), 32'(k));
         chk($sformatf("t4 stall%0d busy", k), 32'(busy), 32'd1);
      end
      cyc(0, 4'h1, 0, 4'h1, 1, "t4 resume");
      chk("t4 resume cnt", 32'(full_stall_cnt), 32'd5);
      // Second stall pushes the 3-bit counter into saturation.
      for (int k = 0; k < 4; k++) begin
         cyc(0, 4'h1, 1, 4'h0, 0, $sformatf("t4 sat%0d", k));
         chk($sformatf("t4 sat%0d cnt", k), 32'(full_stall_cnt), 32'((5 + k > 7) ? 7 : 5 + k));
      end
      cyc(0, 4'h0, 0, 4'h0, 1, "t4 drop");
      chk("t4 saturated cnt", 32'(full_stall_cnt), 32'd7);
      cyc(0, 4'h0, 0, 4'h0, 0, "t4 idle");
      // wfull with an empty slot still accepts.
      cyc(0, 4'h1, 1, 4'h1, 0, "full empty accept");
      cyc(0, 4'h0, 1, 4'h0, 0, "full hold");
      cyc(0, 4'h0, 0, 4'h0, 1, "drain");
      cyc(0, 4'h0, 0, 4'h0, 0, "end idle");
      chk("end busy", 32'(busy), 32'd0);
      chk("scoreboard empty", 32'(sb.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
